// File: rtl/enhance_ctrl.sv
// Front-panel button controller for the HSV enhance stage: auto-repeat, long-press reset, enable toggle.
// Optional acceleration to one step per frame is enabled by defining ENHANCE_CTRL_ACCEL_EN.
module enhance_ctrl #(
   parameter int unsigned REPEAT_DELAY  = 30,
   parameter int unsigned REPEAT_PERIOD = 4,
   parameter int unsigned ACCEL_AFTER   = 8,
   parameter int unsigned RESET_HOLD    = 60,
   parameter bit          EN_INIT       = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vsync,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_left,
   input  logic btn_right,
   input  logic btn_center,
   output logic inc_saturation,
   output logic dec_saturation,
   output logic inc_brightness,
   output logic dec_brightness,
   output logic enhance_en,
   output logic busy
);

   if (REPEAT_DELAY < 1 || REPEAT_DELAY > 255) begin : g_chk_rd
      $error("REPEAT_DELAY out of range");
   end
   if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255) begin : g_chk_rp
      $error("REPEAT_PERIOD out of range");
   end
   if (ACCEL_AFTER < 1 || ACCEL_AFTER > 255) begin : g_chk_aa
      $error("ACCEL_AFTER out of range");
   end
   if (RESET_HOLD < 2 || RESET_HOLD > 255) begin : g_chk_rh
      $error("RESET_HOLD out of range");
   end

`ifdef ENHANCE_CTRL_ACCEL_EN
   typedef enum logic [2:0] {
      IDLE, DELAY, REPEAT, FAST, CHOLD, CWAIT
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, DELAY, REPEAT, CHOLD, CWAIT
   } state_t;
`endif

   state_t     state;
   logic [4:0] btn_s1;
   logic [4:0] btn_s2;
   logic       vsync_q;
   logic       tick;
   logic [3:0] dir;
   logic       center;
   logic       dir_valid;
   logic [3:0] d_cur;
   logic [3:0] key;
   logic [3:0] req;
   logic [7:0] cnt;
   logic [7:0] cnt_inc;
   logic [3:0] step_req;

   // Direction bits ordered {right,left,up,down} so they map 1:1 onto req.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1  <= '0;
         btn_s2  <= '0;
         vsync_q <= 1'b0;
      end else begin
         btn_s1  <= {btn_center, btn_right, btn_left, btn_up, btn_down};
         btn_s2  <= btn_s1;
         vsync_q <= vsync;
      end
   end

   assign tick      = vsync & ~vsync_q;
   assign center    = btn_s2[4];
   assign dir       = btn_s2[3:0];
   assign dir_valid = !center && (dir != 4'd0) && ((dir & (dir - 4'd1)) == 4'd0);
   assign d_cur     = dir_valid ? dir : 4'd0;
   assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
   assign step_req  = enhance_en ? key : 4'd0;

`ifdef ENHANCE_CTRL_ACCEL_EN
   logic [7:0] rep;
   logic [7:0] rep_inc;
   assign rep_inc = (rep == 8'hFF) ? rep : rep + 8'd1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         key        <= '0;
         req        <= '0;
         enhance_en <= EN_INIT;
`ifdef ENHANCE_CTRL_ACCEL_EN
         rep        <= '0;
`endif
      end else if (tick) begin
         req <= '0;
         unique case (state)
            IDLE: begin
               if (center) begin
                  cnt   <= 8'd1;
                  state <= CHOLD;
               end else if (dir_valid) begin
                  req   <= enhance_en ? dir : 4'd0;
                  key   <= dir;
                  cnt   <= '0;
`ifdef ENHANCE_CTRL_ACCEL_EN
                  rep   <= '0;
`endif
                  state <= DELAY;
               end
            end
            CHOLD: begin
               if (center) begin
                  cnt <= cnt_inc;
                  if (cnt_inc == 8'(RESET_HOLD)) begin
                     req   <= 4'hF;
                     state <= CWAIT;
                  end
               end else begin
                  enhance_en <= ~enhance_en;
                  state      <= IDLE;
               end
            end
            CWAIT: begin
               if (!center) state <= IDLE;
            end
            default: begin
               // Any change of the held key restarts or abandons the repeat.
               if (d_cur != key) begin
                  if (dir_valid) begin
                     req   <= enhance_en ? dir : 4'd0;
                     key   <= dir;
                     cnt   <= '0;
`ifdef ENHANCE_CTRL_ACCEL_EN
                     rep   <= '0;
`endif
                     state <= DELAY;
                  end else begin
                     state <= IDLE;
                  end
               end else if (state == DELAY) begin
                  cnt <= cnt_inc;
                  if (cnt_inc == 8'(REPEAT_DELAY)) begin
                     req   <= step_req;
                     cnt   <= '0;
`ifdef ENHANCE_CTRL_ACCEL_EN
                     rep   <= 8'd1;
`endif
                     state <= REPEAT;
                  end
               end else if (state == REPEAT) begin
                  cnt <= cnt_inc;
                  if (cnt_inc == 8'(REPEAT_PERIOD)) begin
                     req <= step_req;
                     cnt <= '0;
`ifdef ENHANCE_CTRL_ACCEL_EN
                     rep <= rep_inc;
                     if (rep_inc >= 8'(ACCEL_AFTER)) state <= FAST;
`endif
                  end
               end else begin
                  req <= step_req;
               end
            end
         endcase
      end
   end

   assign inc_saturation = req[3];
   assign dec_saturation = req[2];
   assign inc_brightness = req[1];
   assign dec_brightness = req[0];
   assign busy           = (state != IDLE);

endmodule
